iter_shifter: RTL and testbench
===============================

Name: iter_shifter

Overview:
- Multicycle, parametrised shift unit for the processor datapath.
- Shifts a WIDTH-bit operand by up to 2^SHAMT_W-1 positions, advancing at most STEP positions per clock.
- Supports logical left, logical right, arithmetic right and rotate-left modes.
- Uses a start/ready handshake so the ALU stall logic can share it, in the same way the multdiv unit is shared.

Parameters:
- WIDTH, 32, operand/result width in bits (>=2).
- SHAMT_W, 5, width of the shift-amount input.
- STEP, 1, maximum positions shifted per cycle (1 <= STEP <= WIDTH-1).

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- ctrl_start  in  1  request; sampled only when busy=0.
- ctrl_mode  in  2  00=SLL, 01=SRL, 10=SRA, 11=ROL; latched at start.
- data_operand  in  WIDTH  value to shift; latched at start.
- data_shamt  in  SHAMT_W  shift amount; latched at start.
- data_result  out  WIDTH  working/result register.
- data_resultRDY  out  1  one-cycle pulse: data_result is final.
- busy  out  1  high while an operation is in progress.

Behaviour:
- Reset (async, active-high): state=IDLE; data_result=0; data_resultRDY=0; busy=0; internal count=0; latched mode=00.
- Reset asserted mid-operation: the operation is aborted immediately and no RDY pulse is produced.
- States: IDLE, RUN. busy = (state==RUN), decoded from registered state.
- IDLE, with ctrl_start=1 at a rising edge:
  - data_result <= data_operand, count <= data_shamt, mode latched, state -> RUN.
- IDLE, with ctrl_start=0: all registers hold.
- RUN, each edge:
  - Let k = min(STEP, count).
  - data_result <= data_result shifted by k in the latched mode; count <= count - k.
  - If count <= STEP: data_resultRDY <= 1 and state -> IDLE. Otherwise data_resultRDY <= 0.
- IDLE: data_resultRDY <= 0 on every edge, except when the RUN completion rule above sets it. Net effect: RDY is high for exactly one cycle.
- Mode rules, per position shifted:
  - SLL: zero enters at bit 0.
  - SRL: zero enters at MSB.
  - SRA: the current MSB is replicated into MSB.
  - ROL: old MSB enters at bit 0.
- Latency: RDY is high in the cycle following edge s+N, where s is the start-sampling edge and N = max(1, ceil(shamt/STEP)). shamt=0 gives N=1 with an unchanged result.
- Shift amount >= WIDTH is legal and is not reduced modulo WIDTH:
  - SLL/SRL: result is 0.
  - SRA: result is all sign bits.
  - ROL: result is rotation by shamt mod WIDTH (natural result of iterating).
- ctrl_start while busy=1: ignored; the inputs are not latched.
- ctrl_start in the same cycle RDY is high: accepted, since state is IDLE. data_result begins updating at that edge, so the consumer must capture the result while RDY=1.
- data_result is held stable in IDLE until the next accepted start.
- Changes to the inputs after the start edge have no effect on the operation in progress.

Test Plan:
- Reset then idle:
  - Stimulus: assert reset asynchronously mid-cycle.
  - Required: data_result=0, RDY=0 and busy=0 immediately. With no start, these hold for 10 cycles.
- SLL, STEP=1:
  - Stimulus: operand 0x0000_0001, shamt=4, mode=00.
  - Required: busy for exactly 4 cycles, RDY for 1 cycle, result 0x0000_0010.
- SRA vs SRL, STEP=1:
  - Stimulus: operand 0x8000_00F0, shamt=4.
  - Required: SRA gives 0xF800_000F; SRL gives 0x0800_000F. Each takes 4 cycles.
- ROL and large shamt, STEP=8:
  - Stimulus: operand 0x1234_5678, shamt=12, mode=11.
  - Required: result 0x4567_8123 after 2 cycles.
  - Stimulus: shamt=31 with SLL on 0xFFFF_FFFF.
  - Required: result 0x8000_0000 after 4 cycles.
- Handshake edges:
  - Stimulus: shamt=0.
  - Required: RDY in the cycle after the start edge, result equals the operand.
  - Stimulus: ctrl_start pulsed while busy=1.
  - Required: ignored, and the first result is correct.
  - Stimulus: back-to-back start asserted during the RDY cycle.
  - Required: second op accepted; both results correct.
- Reset mid-operation:
  - Stimulus: STEP=1, shamt=20; assert reset after 5 cycles, release it, start a new SRL of 0xFF by 4.
  - Required: no RDY pulse for the aborted op; new result 0x0000_000F with correct 4-cycle latency.

Source files
------------

// File: rtl/iter_shifter_if.sv
// Start/ready bundle for the iterative shifter, shared by the ALU stall logic.
interface iter_shifter_if #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
);
  // Handshake: ctrl_start is a request, taken only on an edge where busy=0.
  // data_resultRDY pulses for one cycle when data_result is final.
  logic               ctrl_start;
  logic [1:0]         ctrl_mode;
  logic [WIDTH-1:0]   data_operand;
  logic [SHAMT_W-1:0] data_shamt;
  logic [WIDTH-1:0]   data_result;
  logic               data_resultRDY;
  logic               busy;

  modport master (
    output ctrl_start, ctrl_mode, data_operand, data_shamt,
    input  data_result, data_resultRDY, busy
  );

  modport slave (
    input  ctrl_start, ctrl_mode, data_operand, data_shamt,
    output data_result, data_resultRDY, busy
  );
endinterface

// File: rtl/iter_shifter.sv
// Multicycle shifter: SLL/SRL/SRA/ROL, at most STEP positions per clock.
module iter_shifter #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5,
  parameter int STEP    = 1
) (
  input  logic          clock,
  input  logic          reset,
  iter_shifter_if.slave bus,
  output logic          dbg_state
);
  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   result_q, shifted;
  logic [SHAMT_W-1:0] count_q;
  logic [1:0]         mode_q;
  logic               rdy_q;
  logic [31:0]        count_ext, k;
  logic               last;

  assign count_ext = 32'(count_q);
  assign k         = (count_ext < 32'(STEP)) ? count_ext : 32'(STEP);
  assign last      = (count_ext <= 32'(STEP));

  function automatic logic [WIDTH-1:0] shift1(input logic [WIDTH-1:0] v,
                                              input logic [1:0] m);
    case (m)
      2'b00:   shift1 = {v[WIDTH-2:0], 1'b0};
      2'b01:   shift1 = {1'b0, v[WIDTH-1:1]};
      2'b10:   shift1 = {v[WIDTH-1], v[WIDTH-1:1]};
      default: shift1 = {v[WIDTH-2:0], v[WIDTH-1]};
    endcase
  endfunction

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.ctrl_start) state_d = RUN;
      RUN:     if (last)           state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from registered state
  always_comb begin
    bus.busy           = (state_q == RUN);
    bus.data_result    = result_q;
    bus.data_resultRDY = rdy_q;
    dbg_state          = state_q;
  end

  // Unrolled chain of single-position shifts; stages beyond k pass through.
  always_comb begin
    shifted = result_q;
    for (int i = 0; i < STEP; i++) begin
      if (32'(i) < k) shifted = shift1(shifted, mode_q);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      result_q <= '0;
      count_q  <= '0;
      mode_q   <= 2'b00;
      rdy_q    <= 1'b0;
    end else if (state_q == IDLE) begin
      rdy_q <= 1'b0;
      if (bus.ctrl_start) begin
        result_q <= bus.data_operand;
        count_q  <= bus.data_shamt;
        mode_q   <= bus.ctrl_mode;
      end
    end else begin
      result_q <= shifted;
      count_q  <= count_q - k[SHAMT_W-1:0];
      rdy_q    <= last;
    end
  end
endmodule

// File: tb/tb_iter_shifter.sv
// Bench for iter_shifter: STEP=1, STEP=8 and a narrow WIDTH=8/STEP=3 instance.
module tb_iter_shifter;
  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  iter_shifter_if #(.WIDTH(32), .SHAMT_W(5)) bus1 ();
  iter_shifter_if #(.WIDTH(32), .SHAMT_W(5)) bus8 ();
  iter_shifter_if #(.WIDTH(8),  .SHAMT_W(5)) busw ();
  logic dbg1, dbg8, dbgw;

  iter_shifter #(.WIDTH(32), .SHAMT_W(5), .STEP(1)) u_s1 (
    .clock(clock), .reset(reset), .bus(bus1), .dbg_state(dbg1));
  iter_shifter #(.WIDTH(32), .SHAMT_W(5), .STEP(8)) u_s8 (
    .clock(clock), .reset(reset), .bus(bus8), .dbg_state(dbg8));
  iter_shifter #(.WIDTH(8), .SHAMT_W(5), .STEP(3)) u_w8 (
    .clock(clock), .reset(reset), .bus(busw), .dbg_state(dbgw));

  int tests = 0;
  int fails = 0;
  logic [31:0] exp_q1[$];
  logic [31:0] exp_q8[$];
  logic [31:0] exp_qw[$];

  typedef struct {
    int          sel;
    logic [1:0]  mode;
    logic [31:0] op;
    logic [4:0]  sh;
    logic [31:0] exp;
    int          cyc;
  } vec_t;
  vec_t vecs[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name);
    tests++;
    fails++;
    $display("FAIL %s: RDY pulse with no result expected", name);
  endtask

  // Scoreboard monitors
  always @(negedge clock) begin
    if (bus1.data_resultRDY === 1'b1) begin
      if (exp_q1.size() == 0) unexpected("rdy_s1");
      else check("result_s1", bus1.data_result, exp_q1.pop_front());
    end
    if (bus8.data_resultRDY === 1'b1) begin
      if (exp_q8.size() == 0) unexpected("rdy_s8");
      else check("result_s8", bus8.data_result, exp_q8.pop_front());
    end
    if (busw.data_resultRDY === 1'b1) begin
      if (exp_qw.size() == 0) unexpected("rdy_w8");
      else check("result_w8", 32'(busw.data_result), exp_qw.pop_front());
    end
  end

  task automatic drive(input int sel, input logic st, input logic [1:0] m,
                       input logic [31:0] op, input logic [4:0] sh);
    case (sel)
      1: begin bus1.ctrl_start = st; bus1.ctrl_mode = m; bus1.data_operand = op; bus1.data_shamt = sh; end
      8: begin bus8.ctrl_start = st; bus8.ctrl_mode = m; bus8.data_operand = op; bus8.data_shamt = sh; end
      default: begin busw.ctrl_start = st; busw.ctrl_mode = m; busw.data_operand = op[7:0]; busw.data_shamt = sh; end
    endcase
  endtask

  task automatic push(input int sel, input logic [31:0] exp);
    case (sel)
      1: exp_q1.push_back(exp);
      8: exp_q8.push_back(exp);
      default: exp_qw.push_back(exp);
    endcase
  endtask

  function automatic logic get_rdy(input int sel);
    case (sel)
      1: return bus1.data_resultRDY === 1'b1;
      8: return bus8.data_resultRDY === 1'b1;
      default: return busw.data_resultRDY === 1'b1;
    endcase
  endfunction

  function automatic logic get_busy(input int sel);
    case (sel)
      1: return bus1.busy === 1'b1;
      8: return bus8.busy === 1'b1;
      default: return busw.busy === 1'b1;
    endcase
  endfunction

  // Waits (bounded) for RDY; n = edges after the start edge, b = busy cycles.
  task automatic wait_rdy(input int sel, output int n, output int b);
    n = 0;
    b = 0;
    while (!get_rdy(sel) && n < 100) begin
      if (get_busy(sel)) b++;
      @(negedge clock);
      n++;
    end
  endtask

  task automatic run_op(input int sel, input logic [1:0] m, input logic [31:0] op,
                        input logic [4:0] sh, input logic [31:0] exp, input int cyc,
                        input string name);
    int n, b;
    @(negedge clock);
    drive(sel, 1'b1, m, op, sh);
    push(sel, exp);
    @(negedge clock);
    drive(sel, 1'b0, 2'b00, 32'h0, 5'd0);
    wait_rdy(sel, n, b);
    check({name, "_latency"}, 32'(n), 32'(cyc));
    check({name, "_busy_cycles"}, 32'(b), 32'(cyc));
  endtask

  function automatic logic [31:0] ref_shift(input logic [1:0] m, input logic [31:0] op,
                                            input logic [4:0] sh);
    int s;
    s = int'(sh);
    case (m)
      2'b00:   return op << s;
      2'b01:   return op >> s;
      2'b10:   return 32'($signed(op) >>> s);
      default: return (s == 0) ? op : ((op << s) | (op >> (32 - s)));
    endcase
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, b;
    logic [1:0]  m;
    logic [31:0] op, e;
    logic [4:0]  sh;
    int          sel, step, cyc;

    vecs[0]  = '{1, 2'b00, 32'h00000001, 5'd4,  32'h00000010, 4};
    vecs[1]  = '{1, 2'b10, 32'h800000F0, 5'd4,  32'hF800000F, 4};
    vecs[2]  = '{1, 2'b01, 32'h800000F0, 5'd4,  32'h0800000F, 4};
    vecs[3]  = '{8, 2'b11, 32'h12345678, 5'd12, 32'h45678123, 2};
    vecs[4]  = '{8, 2'b00, 32'hFFFFFFFF, 5'd31, 32'h80000000, 4};
    vecs[5]  = '{1, 2'b10, 32'hDEADBEEF, 5'd0,  32'hDEADBEEF, 1};
    vecs[6]  = '{8, 2'b11, 32'hDEADBEEF, 5'd0,  32'hDEADBEEF, 1};
    vecs[7]  = '{8, 2'b10, 32'h80000000, 5'd31, 32'hFFFFFFFF, 4};
    vecs[8]  = '{1, 2'b11, 32'h80000001, 5'd1,  32'h00000003, 1};
    vecs[9]  = '{8, 2'b01, 32'hF0000000, 5'd31, 32'h00000001, 4};
    vecs[10] = '{8, 2'b11, 32'h89ABCDEF, 5'd31, 32'hC4D5E6F7, 4};
    vecs[11] = '{3, 2'b00, 32'h000000FF, 5'd20, 32'h00000000, 7};
    vecs[12] = '{3, 2'b10, 32'h00000080, 5'd20, 32'h000000FF, 7};
    vecs[13] = '{3, 2'b11, 32'h00000081, 5'd10, 32'h00000006, 4};

    drive(1, 1'b0, 2'b00, 32'h0, 5'd0);
    drive(8, 1'b0, 2'b00, 32'h0, 5'd0);
    drive(3, 1'b0, 2'b00, 32'h0, 5'd0);

    // Asynchronous reset, asserted between edges
    #3 reset = 1'b1;
    #1;
    check("reset_result_s1", bus1.data_result, 32'h0);
    check("reset_flags_s1", {29'd0, bus1.data_resultRDY, bus1.busy, dbg1}, 32'h0);
    check("reset_result_s8", bus8.data_result, 32'h0);
    check("reset_result_w8", 32'(busw.data_result), 32'h0);
    check("reset_flags_w8", {29'd0, busw.data_resultRDY, busw.busy, dbgw}, 32'h0);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      check("idle_hold_result", bus1.data_result, 32'h0);
      check("idle_hold_flags", {29'd0, bus1.data_resultRDY, bus1.busy, bus8.busy}, 32'h0);
    end

    for (int i = 0; i < 14; i++)
      run_op(vecs[i].sel, vecs[i].mode, vecs[i].op, vecs[i].sh, vecs[i].exp, vecs[i].cyc,
             $sformatf("vec%0d", i));

    for (int i = 0; i < 12; i++) begin
      sel  = (i % 2 == 0) ? 1 : 8;
      step = sel;
      m    = 2'($urandom_range(0, 3));
      op   = $urandom;
      sh   = 5'($urandom_range(0, 31));
      e    = ref_shift(m, op, sh);
      cyc  = (sh == 0) ? 1 : (int'(sh) + step - 1) / step;
      run_op(sel, m, op, sh, e, cyc, $sformatf("rand%0d", i));
    end

    // Start pulsed while busy must be ignored
    @(negedge clock);
    drive(1, 1'b1, 2'b00, 32'h00000001, 5'd4);
    push(1, 32'h00000010);
    @(negedge clock);
    drive(1, 1'b0, 2'b00, 32'h0, 5'd0);
    n = 0;
    while (!get_rdy(1) && n < 100) begin
      if (n == 1) drive(1, 1'b1, 2'b11, 32'h0000FFFF, 5'd7);
      else        drive(1, 1'b0, 2'b00, 32'h0, 5'd0);
      @(negedge clock);
      n++;
    end
    check("busy_ignore_latency", 32'(n), 32'd4);
    repeat (8) @(negedge clock);
    check("busy_ignore_idle", {31'd0, bus1.busy}, 32'h0);

    // Back-to-back: second start issued during the RDY cycle
    @(negedge clock);
    drive(8, 1'b1, 2'b01, 32'hF0000000, 5'd8);
    push(8, 32'h00F00000);
    @(negedge clock);
    drive(8, 1'b0, 2'b00, 32'h0, 5'd0);
    wait_rdy(8, n, b);
    check("b2b_first_latency", 32'(n), 32'd1);
    drive(8, 1'b1, 2'b11, 32'h12345678, 5'd16);
    push(8, 32'h56781234);
    @(negedge clock);
    drive(8, 1'b0, 2'b00, 32'h0, 5'd0);
    wait_rdy(8, n, b);
    check("b2b_second_latency", 32'(n), 32'd2);

    // Reset in the middle of a long operation
    @(negedge clock);
    drive(1, 1'b1, 2'b01, 32'h12345678, 5'd20);
    @(negedge clock);
    drive(1, 1'b0, 2'b00, 32'h0, 5'd0);
    repeat (5) @(negedge clock);
    #2 reset = 1'b1;
    #1;
    check("abort_result", bus1.data_result, 32'h0);
    check("abort_flags", {30'd0, bus1.data_resultRDY, bus1.busy}, 32'h0);
    @(negedge clock);
    reset = 1'b0;
    run_op(1, 2'b01, 32'h000000FF, 5'd4, 32'h0000000F, 4, "after_abort");

    repeat (4) @(negedge clock);
    check("pending_s1", 32'(exp_q1.size()), 32'd0);
    check("pending_s8", 32'(exp_q8.size()), 32'd0);
    check("pending_w8", 32'(exp_qw.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
